sync_w2r_gray: RTL
==================

Name: sync_w2r_gray

Overview:
Parametrised successor to the two-flop write-pointer synchroniser, used on the read side of the async FIFO.
- Carries a Gray-coded write pointer into the rclk domain through a configurable-depth flop chain.
- Converts it to binary.
- Strobes when the synchronised pointer advances.
- Flags illegal multi-bit Gray transitions, which indicate CDC faults.

Parameters:
ASIZE, 4, FIFO address width; pointer width is ASIZE+1.
STAGES, 2, synchroniser depth; legal range 2..4; any other value is an elaboration error.

Ports:
rclk  input  1  read-domain clock; all logic on posedge.
rrst_n  input  1  synchronous active-low reset, sampled on posedge rclk.
wptr  input  ASIZE+1  Gray write pointer from the wclk domain; asynchronous to rclk.
err_clr  input  1  clears the sticky error flag.
rq2_wptr  output  ASIZE+1  synchronised Gray pointer (last chain stage).
rq_wbin  output  ASIZE+1  binary form of rq2_wptr, registered.
rq_update  output  1  one-cycle pulse; rq_wbin changed this cycle.
rq_err  output  1  sticky; multi-bit Gray step detected.
rq_ready  output  1  high once warm-up completes.

Behaviour:
- Reset (rrst_n=0 at posedge): all chain stages, rq2_wptr, rq_wbin and the warm-up counter go to 0; rq_update=0, rq_err=0, rq_ready=0.
  - Mid-operation reset has identical effect and discards any in-flight value.
- Chain: stage1 <= wptr; stage k <= stage k-1; rq2_wptr = stage STAGES.
  - Latency wptr -> rq2_wptr: STAGES rclk edges. No logic between stages.
- Binary: rq_wbin <= gray2bin(rq2_wptr), so one cycle after rq2_wptr.
  - gray2bin: b[MSB]=g[MSB]; b[i]=b[i+1]^g[i].
  - Total latency wptr -> rq_wbin: STAGES+1 edges.
- Warm-up counter: 0..STAGES+1, increments each cycle after reset release, saturates.
  - rq_ready=1 when count==STAGES+1.
  - Before rq_ready: rq_update and error detection are suppressed; rq_wbin still tracks.
- rq_update: registered. Asserted in the cycle rq_wbin takes a value different from its previous value, only when rq_ready was 1 in the prior cycle.
  - Equal consecutive values give no pulse.
  - Continuous change gives back-to-back pulses.
- Error detection compares rq2_wptr with its previous-cycle value, only when rq_ready=1:
  - Hamming distance 0 or 1: legal.
  - Distance >=2: rq_err <= 1 on the next edge.
  - Gray wrap-around (e.g. 10000 -> 00000 for ASIZE=4) is a 1-bit step and is legal.
- rq_err is sticky.
  - err_clr=1 clears it on the next edge.
  - Simultaneous err_clr and new violation: set wins (rq_err stays 1).
- No backpressure; block is free-running.

Optional Feature:
Macro SYNC_W2R_FILL_EN.
- Defined: adds input rbin (ASIZE+1, local binary read pointer) and output rq_fill (ASIZE+1).
  - rq_fill <= (gray2bin(rq2_wptr) - rbin) mod 2^(ASIZE+1), registered, same cycle as rq_wbin.
  - Reset value 0.
  - rq_fill never exceeds 2^ASIZE under legal FIFO operation; no clamping.
- Undefined: rbin and rq_fill do not exist; otherwise identical behaviour.

Decomposition:
Package cdc_pkg holds:
- constants SYNC_MIN_STAGES=2 and SYNC_MAX_STAGES=4;
- function gray2bin(width-generic);
- function gray_step_ok (Hamming distance <=1).

Sub-module sync_chain (params WIDTH, STAGES; ports rclk, rrst_n, d, q) implements the bare flop chain. It is reusable for the r2w direction.

Test Plan:
- Reset then hold wptr=0: rq_ready rises exactly STAGES+1 cycles after release; rq_update and rq_err stay 0.
- ASIZE=4, STAGES=3: step wptr through Gray sequence 00000, 00001, 00011, 00010 one per cycle after ready → rq_wbin shows 0,1,2,3 with 4-cycle latency and one rq_update pulse per step.
- Wrap: Gray 10000 -> 00000 (binary 31 -> 0) → rq_wbin=0, rq_update=1, rq_err=0.
- Illegal jump 00000 -> 00011 after ready → rq_err=1 STAGES+1 cycles later.
  - Stays 1 with err_clr=0.
  - err_clr pulse → clears; err_clr together with a further violation → stays 1.
- Assert rrst_n=0 mid-sequence with wptr=00110 → all outputs 0 next edge; warm-up restarts; no false rq_err on first post-ready compare.
- SYNC_W2R_FILL_EN defined, rbin=5, wptr Gray of 12 → rq_fill=7.
  - rbin=30, write pointer binary 2 → rq_fill=4 (modular).

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared clock-domain-crossing helpers: synchroniser depth limits and
// Gray-code utilities used by the pointer synchronisers of the async FIFO.
//
// The helpers work on a fixed 32-bit word. Callers zero-extend narrower
// pointers into that word. Zero bits above a pointer's MSB leave the
// Gray-to-binary prefix XOR unchanged, so one function serves every
// pointer width up to CDC_MAX_W.
package cdc_pkg;

    localparam int SYNC_MIN_STAGES = 2;
    localparam int SYNC_MAX_STAGES = 4;
    localparam int CDC_MAX_W       = 32;

    typedef logic [CDC_MAX_W-1:0] cdc_word_t;

    // Gray to binary: b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i].
    function automatic cdc_word_t gray2bin(input cdc_word_t gray);
        cdc_word_t bin;
        bin[CDC_MAX_W-1] = gray[CDC_MAX_W-1];
        for (int i = CDC_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // A legal Gray step changes at most one bit (Hamming distance <= 1).
    function automatic logic gray_step_ok(input cdc_word_t cur, input cdc_word_t prev);
        cdc_word_t   diff;
        int unsigned ones;
        diff = cur ^ prev;
        ones = 32'd0;
        for (int i = 0; i < CDC_MAX_W; i++) begin
            ones = ones + {31'd0, diff[i]};
        end
        return (ones <= 32'd1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Bare multi-flop synchroniser chain. No logic sits between stages, so the
// first flop is the only one that can see a metastable input. The chain is
// direction-agnostic and serves both the w2r and r2w pointer crossings.
module sync_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the asynchronous input through the chain; a synchronous reset clears every stage.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/sync_w2r_gray.sv
// Write-pointer synchroniser for the read side of the async FIFO.
// The block performs these steps in the rclk domain:
//   - carries the Gray write pointer through a STAGES-deep flop chain;
//   - registers its binary form;
//   - pulses rq_update whenever that binary value changes;
//   - sets a sticky rq_err on any multi-bit Gray step, which indicates a CDC fault.
// Update pulses and error checks stay masked until the chain and the binary
// register hold real data (warm-up of STAGES+1 cycles after reset).
//
// Optional build macro SYNC_W2R_FILL_EN adds two ports:
//   - rbin: local binary read pointer;
//   - rq_fill: registered FIFO fill level, (write binary - rbin) mod 2^(ASIZE+1).
module sync_w2r_gray
    import cdc_pkg::*;
#(
    parameter int ASIZE  = 4,
    parameter int STAGES = 2
) (
    input  logic           rclk,
    input  logic           rrst_n,
    input  logic [ASIZE:0] wptr,
    input  logic           err_clr,
    output logic [ASIZE:0] rq2_wptr,
    output logic [ASIZE:0] rq_wbin,
    output logic           rq_update,
    output logic           rq_err,
    output logic           rq_ready
`ifdef SYNC_W2R_FILL_EN
    ,
    input  logic [ASIZE:0] rbin,
    output logic [ASIZE:0] rq_fill
`endif
);

    localparam int PW    = ASIZE + 1;
    localparam int CNT_W = $clog2(STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_DONE = CNT_W'(STAGES + 1);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(STAGES);

    // Reject unsupported configurations at elaboration time.
    if ((STAGES < SYNC_MIN_STAGES) || (STAGES > SYNC_MAX_STAGES)) begin : g_stages_bad
        $error("sync_w2r_gray: STAGES must lie in 2..4");
    end
    if (PW > CDC_MAX_W) begin : g_width_bad
        $error("sync_w2r_gray: pointer wider than cdc_pkg helper word");
    end

    logic [ASIZE:0] prev_wptr_r;
    logic [ASIZE:0] wbin_next_s;
    logic [CNT_W-1:0] warm_cnt_r;
    logic [CNT_W-1:0] warm_cnt_next_s;
    logic           ready_next_s;
    logic           step_bad_s;
    logic           update_next_s;
    logic           err_next_s;

    sync_chain #(
        .WIDTH  (PW),
        .STAGES (STAGES)
    ) u_chain (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .d      (wptr),
        .q      (rq2_wptr)
    );

    // Binary conversion of the synchronised pointer, feeding rq_wbin one cycle later.
    always_comb begin
        wbin_next_s = PW'(gray2bin(cdc_word_t'(rq2_wptr)));
    end

    // The warm-up counter saturates at STAGES+1; ready is asserted on the edge that reaches it.
    always_comb begin
        warm_cnt_next_s = warm_cnt_r;
        if (warm_cnt_r == WARM_DONE) begin
            warm_cnt_next_s = warm_cnt_r;
        end else begin
            warm_cnt_next_s = warm_cnt_r + CNT_W'(1);
        end
        ready_next_s = (warm_cnt_r >= WARM_LAST);
    end

    // Change strobe and Gray step check, both masked until warm-up completes.
    always_comb begin
        update_next_s = 1'b0;
        step_bad_s    = 1'b0;
        if (rq_ready) begin
            update_next_s = (wbin_next_s != rq_wbin);
            step_bad_s    = !gray_step_ok(cdc_word_t'(rq2_wptr), cdc_word_t'(prev_wptr_r));
        end else begin
            update_next_s = 1'b0;
            step_bad_s    = 1'b0;
        end
    end

    // Sticky error: a new violation takes priority over a clear request.
    always_comb begin
        err_next_s = rq_err;
        if (step_bad_s) begin
            err_next_s = 1'b1;
        end else if (err_clr) begin
            err_next_s = 1'b0;
        end else begin
            err_next_s = rq_err;
        end
    end

    // Output and status registers; reset discards all in-flight state.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            prev_wptr_r <= {PW{1'b0}};
            rq_wbin     <= {PW{1'b0}};
            warm_cnt_r  <= {CNT_W{1'b0}};
            rq_ready    <= 1'b0;
            rq_update   <= 1'b0;
            rq_err      <= 1'b0;
        end else begin
            prev_wptr_r <= rq2_wptr;
            rq_wbin     <= wbin_next_s;
            warm_cnt_r  <= warm_cnt_next_s;
            rq_ready    <= ready_next_s;
            rq_update   <= update_next_s;
            rq_err      <= err_next_s;
        end
    end

`ifdef SYNC_W2R_FILL_EN
    // Fill level in modular pointer arithmetic, aligned with rq_wbin.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            rq_fill <= {PW{1'b0}};
        end else begin
            rq_fill <= wbin_next_s - rbin;
        end
    end
`else
    // No fill tracking in this build; the pointer path above is complete.
`endif

endmodule
